// File: rtl/ct_biu_csr_pkg.sv
// Shared constants for the BIU CSR responder: FSM encodings, target codes,
// local register indices and the response layout.
package ct_biu_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DS_WAIT = 2'd1,
    ST_RESP    = 2'd2,
    ST_HOLD    = 2'd3
  } csr_state_e;

  localparam logic [2:0]  TGT_LOCAL   = 3'b000;
  localparam logic [2:0]  TGT_L2C     = 3'b001;

  localparam logic [11:0] IDX_SCRATCH = 12'h000;
  localparam logic [11:0] IDX_TOCFG   = 12'h001;
  localparam logic [11:0] IDX_ERRCNT  = 12'h002;

  localparam logic [15:0] TOCFG_RST   = 16'd255;

  localparam int          ERR_BIT     = 64;

endpackage

// File: rtl/ct_biu_csr_lreg.sv
// Local BIU register bank: SCRATCH, TOCFG (downstream timeout) and the
// saturating ERRCNT. Read data and the illegal-index flag are combinational.
module ct_biu_csr_lreg
  import ct_biu_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic [11:0] idx,
  input  logic [63:0] wdata,
  input  logic        err_inc,
  output logic [63:0] rdata,
  output logic        illegal,
  output logic [15:0] timeout_cfg
);

  logic [63:0] scratch;
  logic [15:0] tocfg;
  logic [31:0] errcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      tocfg   <= TOCFG_RST;
      errcnt  <= '0;
    end else begin
      if (wen && idx == IDX_SCRATCH) scratch <= wdata;
      if (wen && idx == IDX_TOCFG)   tocfg   <= wdata[15:0];
      if (err_inc && errcnt != 32'hFFFF_FFFF) errcnt <= errcnt + 32'd1;
    end
  end

  always_comb begin
    rdata   = '0;
    illegal = 1'b0;
    case (idx)
      IDX_SCRATCH: rdata = scratch;
      IDX_TOCFG:   rdata = {48'd0, tocfg};
      IDX_ERRCNT:  rdata = {32'd0, errcnt};
      default:     illegal = 1'b1;
    endcase
  end

  assign timeout_cfg = tocfg;

endmodule

// File: rtl/ct_biu_csr_resp.sv
// BIU CSR responder: terminates the arbitrated CSR request, serving it locally
// or via the L2C CSR port, and returns a registered one-cycle completion.
module ct_biu_csr_resp
  import ct_biu_csr_pkg::*;
(
  input  logic         forever_cpuclk,
  input  logic         cpurst_b,
  input  logic         biu_csr_sel,
  input  logic [15:0]  biu_csr_op,
  input  logic [63:0]  biu_csr_wdata,
  output logic         biu_csr_cmplt,
  output logic [127:0] biu_csr_rdata,
  output logic         biu_l2c_csr_req,
  output logic         biu_l2c_csr_wen,
  output logic [11:0]  biu_l2c_csr_idx,
  output logic [63:0]  biu_l2c_csr_wdata,
  input  logic         l2c_biu_csr_ack,
  input  logic [63:0]  l2c_biu_csr_rdata
);

  // Handshake: sel is a level held with op/wdata stable until the cmplt
  // pulse; HOLD masks the still-high sel for one cycle after completion.
  csr_state_e state, state_nxt;

  logic        ds_wr;
  logic [11:0] ds_idx;
  logic [63:0] ds_wdata;
  logic [15:0] cnt;
  logic        cmplt_q;
  logic        err_q;
  logic [63:0] rdata_q;

  logic        resp_go, resp_err, lreg_wen;
  logic [63:0] resp_data;
  logic [63:0] lreg_rdata;
  logic        lreg_illegal;
  logic [15:0] timeout_cfg;

  logic [2:0]  req_tgt;
  logic        req_wr;
  logic        loc_err;

  assign req_tgt = biu_csr_op[14:12];
  assign req_wr  = biu_csr_op[15];
  assign loc_err = lreg_illegal || (req_wr && biu_csr_op[11:0] == IDX_ERRCNT);

  ct_biu_csr_lreg u_lreg (
    .clk         (forever_cpuclk),
    .rst_n       (cpurst_b),
    .wen         (lreg_wen),
    .idx         (biu_csr_op[11:0]),
    .wdata       (biu_csr_wdata),
    .err_inc     (resp_go && resp_err),
    .rdata       (lreg_rdata),
    .illegal     (lreg_illegal),
    .timeout_cfg (timeout_cfg)
  );

  always_comb begin
    state_nxt = state;
    resp_go   = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    lreg_wen  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (biu_csr_sel) begin
          if (req_tgt == TGT_LOCAL) begin
            resp_go   = 1'b1;
            resp_err  = loc_err;
            resp_data = (loc_err || req_wr) ? 64'd0 : lreg_rdata;
            lreg_wen  = req_wr && !loc_err;
            state_nxt = ST_RESP;
          end else if (req_tgt == TGT_L2C) begin
            state_nxt = ST_DS_WAIT;
          end else begin
            resp_go   = 1'b1;
            resp_err  = 1'b1;
            state_nxt = ST_RESP;
          end
        end
      end
      ST_DS_WAIT: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (l2c_biu_csr_ack) begin
          resp_go   = 1'b1;
          resp_data = ds_wr ? 64'd0 : l2c_biu_csr_rdata;
          state_nxt = ST_RESP;
        end else if (timeout_cfg != 16'd0 && cnt == timeout_cfg) begin
          resp_go   = 1'b1;
          resp_err  = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_HOLD;
      ST_HOLD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ds_wr    <= 1'b0;
      ds_idx   <= '0;
      ds_wdata <= '0;
      cmplt_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state == ST_DS_WAIT) ? cnt + 16'd1 : 16'd0;
      cmplt_q <= resp_go;
      err_q   <= resp_go && resp_err;
      rdata_q <= resp_go ? resp_data : 64'd0;
      if (state == ST_IDLE && biu_csr_sel) begin
        ds_wr    <= req_wr;
        ds_idx   <= biu_csr_op[11:0];
        ds_wdata <= biu_csr_wdata;
      end
    end
  end

  always_comb begin
    biu_csr_rdata          = '0;
    biu_csr_rdata[63:0]    = rdata_q;
    biu_csr_rdata[ERR_BIT] = err_q;
  end

  assign biu_csr_cmplt     = cmplt_q;
  assign biu_l2c_csr_req   = (state == ST_DS_WAIT);
  assign biu_l2c_csr_wen   = biu_l2c_csr_req && ds_wr;
  assign biu_l2c_csr_idx   = ds_idx;
  assign biu_l2c_csr_wdata = ds_wdata;

endmodule

// File: tb/tb_ct_biu_csr_resp.sv
// Directed bench for ct_biu_csr_resp: local bank, L2C ack/timeout paths,
// illegal accesses, back-to-back sel and asynchronous reset mid-transaction.
module tb_ct_biu_csr_resp;

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic [15:0]  op;
  logic [63:0]  wdata;
  logic         cmplt;
  logic [127:0] rdata;
  logic         req;
  logic         wen;
  logic [11:0]  idx;
  logic [63:0]  ds_wdata;
  logic         ack;
  logic [63:0]  ack_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ERR_RESP = 128'd1 << 64;

  ct_biu_csr_resp dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (rst_n),
    .biu_csr_sel       (sel),
    .biu_csr_op        (op),
    .biu_csr_wdata     (wdata),
    .biu_csr_cmplt     (cmplt),
    .biu_csr_rdata     (rdata),
    .biu_l2c_csr_req   (req),
    .biu_l2c_csr_wen   (wen),
    .biu_l2c_csr_idx   (idx),
    .biu_l2c_csr_wdata (ds_wdata),
    .l2c_biu_csr_ack   (ack),
    .l2c_biu_csr_rdata (ack_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One local/illegal access: cmplt at cycle 1, quiet in HOLD, IDLE at cycle 3.
  task automatic local_access(input string tag, input logic [15:0] a_op,
                              input logic [63:0] a_wd, input logic [127:0] exp);
    sel = 1'b1; op = a_op; wdata = a_wd;
    tick();
    chk({tag, "_cmplt"}, {127'd0, cmplt}, 128'd1);
    chk({tag, "_rdata"}, rdata, exp);
    sel = 1'b0;
    tick();
    chk({tag, "_hold"}, {127'd0, cmplt}, 128'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; op = '0; wdata = '0; ack = 1'b0; ack_rdata = '0;
    tick(); tick();
    chk("rst_cmplt", {127'd0, cmplt}, 128'd0);
    chk("rst_rdata", rdata, 128'd0);
    chk("rst_req",   {127'd0, req}, 128'd0);
    chk("rst_ds",    {51'd0, wen, idx, ds_wdata}, 128'd0);
    rst_n = 1'b1;
    tick();

    local_access("rd_scratch0", 16'h0000, 64'd0, 128'd0);
    local_access("rd_tocfg0",   16'h0001, 64'd0, 128'd255);
    local_access("rd_errcnt0",  16'h0002, 64'd0, 128'd0);
    local_access("wr_scratch",  16'h8000, 64'hDEAD_BEEF_0123_4567, 128'd0);
    local_access("rd_scratch1", 16'h0000, 64'd0, 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);

    // L2C read idx 0x010, ack in cycle 4.
    sel = 1'b1; op = 16'h1010; wdata = 64'd0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("l2c_rd_req_c%0d", c), {127'd0, req}, 128'd1);
      chk($sformatf("l2c_rd_cmplt_c%0d", c), {127'd0, cmplt}, 128'd0);
      if (c == 1) chk("l2c_rd_ds", {115'd0, wen, idx}, {115'd0, 1'b0, 12'h010});
      if (c == 4) begin ack = 1'b1; ack_rdata = 64'h55; end
    end
    tick();
    ack = 1'b0; ack_rdata = '0;
    chk("l2c_rd_req_c5", {127'd0, req}, 128'd0);
    chk("l2c_rd_cmplt_c5", {127'd0, cmplt}, 128'd1);
    chk("l2c_rd_rdata", rdata, 128'h55);
    sel = 1'b0;
    tick();
    chk("l2c_rd_hold", {127'd0, cmplt}, 128'd0);
    tick();

    // TOCFG=3, then an unacknowledged L2C write times out.
    local_access("wr_tocfg", 16'h8001, 64'hFFFF_FFFF_0000_0003, 128'd0);
    local_access("rd_tocfg3", 16'h0001, 64'd0, 128'd3);
    sel = 1'b1; op = 16'h9020; wdata = 64'h1234_5678_9ABC_DEF0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("to_req_c%0d", c), {127'd0, req}, 128'd1);
      chk($sformatf("to_cmplt_c%0d", c), {127'd0, cmplt}, 128'd0);
      if (c == 1) chk("to_ds", {51'd0, wen, idx, ds_wdata},
                      {51'd0, 1'b1, 12'h020, 64'h1234_5678_9ABC_DEF0});
    end
    tick();
    chk("to_cmplt_c5", {127'd0, cmplt}, 128'd1);
    chk("to_rdata", rdata, ERR_RESP);
    chk("to_req_c5", {127'd0, req}, 128'd0);
    sel = 1'b0;
    tick(); tick(); tick();
    ack = 1'b1; ack_rdata = 64'hAA;
    tick();
    ack = 1'b0; ack_rdata = '0;
    chk("late_ack_cmplt", {127'd0, cmplt}, 128'd0);
    chk("late_ack_req", {127'd0, req}, 128'd0);
    tick();
    local_access("rd_errcnt1", 16'h0002, 64'd0, 128'd1);

    // Illegal target and illegal local index; SCRATCH untouched.
    local_access("bad_tgt", 16'hF000, 64'h1111, ERR_RESP);
    local_access("bad_idx", 16'h8005, 64'h2222, ERR_RESP);
    local_access("rd_errcnt3", 16'h0002, 64'd0, 128'd3);
    local_access("rd_scratch2", 16'h0000, 64'd0, 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);

    // sel held across two requests.
    sel = 1'b1; op = 16'h0000;
    tick();
    chk("b2b_cmplt1", {127'd0, cmplt}, 128'd1);
    chk("b2b_rdata1", rdata, 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);
    op = 16'h0001;
    tick();
    chk("b2b_hold", {127'd0, cmplt}, 128'd0);
    tick();
    chk("b2b_accept", {127'd0, cmplt}, 128'd0);
    tick();
    chk("b2b_cmplt2", {127'd0, cmplt}, 128'd1);
    chk("b2b_rdata2", rdata, 128'd3);
    sel = 1'b0;
    tick();
    chk("b2b_after", {127'd0, cmplt}, 128'd0);
    tick();
    chk("b2b_no_dbl", {127'd0, cmplt}, 128'd0);
    tick();

    // Asynchronous reset while waiting on the L2C port.
    sel = 1'b1; op = 16'h1030;
    tick();
    chk("rstw_req_pre", {127'd0, req}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_req", {127'd0, req}, 128'd0);
    chk("rstw_cmplt", {127'd0, cmplt}, 128'd0);
    sel = 1'b0;
    tick();
    chk("rstw_quiet", {126'd0, cmplt, req}, 128'd0);
    rst_n = 1'b1;
    tick();
    local_access("rstw_scratch", 16'h0000, 64'd0, 128'd0);
    local_access("rstw_tocfg",   16'h0001, 64'd0, 128'd255);
    local_access("rstw_errcnt",  16'h0002, 64'd0, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_biu_csr_resp.md
# ct_biu_csr_resp

BIU-side responder for the core's CSR request channel: accepts the arbitrated `biu_csr_sel/op/wdata` request, services it from a small local BIU register bank or by forwarding it to the L2C CSR port, and returns a one-cycle `biu_csr_cmplt` pulse with `biu_csr_rdata`. It sits behind the cp0/hpcp CSR request arbiter and terminates that protocol.

## Interface
- No parameters. Constants live in the package (see Structure).
- `forever_cpuclk` in 1: core clock.
- `cpurst_b` in 1: asynchronous, active-low reset.
- `biu_csr_sel` in 1: request valid (level); the requester holds it with op/wdata stable until cmplt.
- `biu_csr_op` in 16: [15] 1=write/0=read; [14:12] target (000 local, 001 L2C, others illegal); [11:0] register index.
- `biu_csr_wdata` in 64: write data.
- `biu_csr_cmplt` out 1: one-cycle completion pulse, registered.
- `biu_csr_rdata` out 128: [63:0] read data; [64] access error; [127:65] zero. Registered, and valid only while cmplt=1.
- `biu_l2c_csr_req` out 1: downstream request, held until ack or timeout.
- `biu_l2c_csr_wen` out 1: downstream write enable.
- `biu_l2c_csr_idx` out 12: downstream index.
- `biu_l2c_csr_wdata` out 64: downstream write data.
- `l2c_biu_csr_ack` in 1: one-cycle downstream acknowledge.
- `l2c_biu_csr_rdata` in 64: downstream read data, valid with ack.

## Operation
- FSM states: IDLE, DS_WAIT, RESP, HOLD.
- **IDLE**
  - On `sel`=1, capture op and wdata.
  - Local target: perform the access on this edge, then go to RESP.
  - L2C target: go to DS_WAIT.
  - Illegal target: go to RESP with error=1, rdata 0, no side effect.
- **DS_WAIT**
  - `req`=1, with wen/idx/wdata taken from the captured op.
  - Count cycles with a 16-bit counter that clears on entry.
  - On ack: latch rdata (zero for writes), error=0, go to RESP.
  - Otherwise, if timeout_cfg≠0 and the count equals timeout_cfg: error=1, rdata 0, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
- **RESP**: cmplt=1, rdata driven, then go to HOLD.
- **HOLD**: ignore `sel` for one cycle (the requester's sel is still high), then go to IDLE.
- Local register bank:
  - idx 0x000 SCRATCH: 64-bit RW, reset 0.
  - idx 0x001 TOCFG: [15:0] RW, reset 16'd255; upper bits read 0 and ignore writes; value 0 disables the timeout.
  - idx 0x002 ERRCNT: RO, [31:0]; counts every completion with error=1 and saturates at 0xFFFF_FFFF. Writes to it are an error.
  - Any other index: error=1, no write.
- Every completion with error=1 increments ERRCNT, including illegal targets and timeouts.
- An ack arriving outside DS_WAIT (e.g. a late ack after timeout) is ignored.

## Timing
- Reset values: all outputs 0; FSM in IDLE; counter 0; registers as listed above.
- Asserting reset mid-transaction drops `req` and `cmplt` immediately (asynchronous), and no completion is issued.
- Local or illegal access: sel seen in IDLE at cycle 0 → cmplt at cycle 1 → HOLD at cycle 2 → next request accepted at cycle 3 at the earliest.
- L2C access:
  - `req` rises at cycle 1.
  - Ack at cycle k≥1 → `req` falls at k+1 with cmplt=1 at k+1.
  - Timeout with TOCFG=N → cmplt at cycle N+2.
- A TOCFG write takes effect for the next downstream access, never the one in flight (none can be in flight).
- A back-to-back request from the other requester (sel never drops) is accepted in the IDLE cycle after HOLD.

## Structure
- Package/header `ct_biu_csr_pkg` holds:
  - FSM state encodings;
  - target codes (LOCAL=3'b000, L2C=3'b001);
  - local indices 0x000/0x001/0x002;
  - TOCFG reset value 16'd255;
  - rdata error bit position 64.
- One sub-module, `ct_biu_csr_lreg`: the local register bank.
  - Inputs: write strobe, index, wdata, error-increment pulse.
  - Outputs: combinational read data, an illegal-index flag, timeout_cfg.
- FSM, timeout counter and the downstream port stay in the top module.

## Test plan
- Write SCRATCH 0xDEAD_BEEF_0123_4567, then read it back → second cmplt 1 cycle after acceptance, rdata[63:0]=0xDEAD_BEEF_0123_4567, rdata[64]=0.
- L2C read idx 0x010, ack at cycle 4 with rdata 0x55 → req high for cycles 1–4, cmplt at cycle 5, rdata[63:0]=0x55.
- TOCFG=3, L2C write with no ack → cmplt at cycle 5 with rdata[64]=1, ERRCNT reads 1; a late ack at cycle 8 is ignored.
- op target 3'b111 and local idx 0x005 → each gives cmplt at cycle 1 with error=1; ERRCNT increases by 2; SCRATCH is unchanged.
- Hold sel high across two requests → exactly one cmplt per request, with two cycles between cmplt and the next acceptance; no double completion.
- Assert cpurst_b low while in DS_WAIT → req=0 and cmplt=0 immediately; after release SCRATCH=0, TOCFG=255, ERRCNT=0.
